// File: rtl/vga_console_pkg.sv
// Shared state encoding and control-code constants for the text console.
package vga_console_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CLEAR_ALL  = 2'd1,
        CLEAR_LINE = 2'd2
    } state_t;

    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

endpackage

// File: rtl/vga_console_cursor.sv
// Cursor column/row counters plus the linear buffer address of the cursor
// cell and of the start of the cursor row.
module vga_console_cursor
    import vga_console_pkg::*;
#(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              newline,
    input  logic              ret,
    input  logic              home,
    input  logic              back,
    output logic [6:0]        col,
    output logic [4:0]        row,
    output logic              wrap,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] line_base
);

    logic [ADDR_W-1:0] row_ext;
    logic              last_row;

    assign row_ext  = ADDR_W'(row);
    assign wrap     = (col == 7'(COLS - 1));
    assign last_row = (row == 5'(ROWS - 1));

    // For the standard 80-column mode the row multiply is two shifts and an add.
    generate
        if (COLS == 80) begin : g_shift_mul
            assign line_base = (row_ext << 6) + (row_ext << 4);
        end else begin : g_generic_mul
            assign line_base = row_ext * ADDR_W'(COLS);
        end
    endgenerate

    assign addr = line_base + ADDR_W'(col);

    // Cursor movement; home beats everything, and an increment past the last
    // column behaves exactly like a newline (bottom row wraps to row 0).
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (home) begin
            col <= '0;
            row <= '0;
        end else if (newline || (inc && wrap)) begin
            col <= '0;
            row <= last_row ? 5'd0 : row + 5'd1;
        end else if (inc) begin
            col <= col + 7'd1;
        end else if (ret) begin
            col <= '0;
        end else if (back && (col != 7'd0)) begin
            col <= col - 7'd1;
        end
    end

endmodule

// File: rtl/vga_text_console.sv
// Character-stream console: accepts bytes, tracks the cursor, interprets
// control codes and drives the text buffer write port, including the
// multi-cycle screen and line clears.
module vga_text_console
    import vga_console_pkg::*;
#(
    parameter int          COLS   = 80,
    parameter int          ROWS   = 30,
    parameter int          ADDR_W = 12,
    parameter logic [7:0]  BLANK  = 8'h20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              clear,
    output logic              busy,
    output logic [6:0]        cursor_x,
    output logic [4:0]        cursor_y,
    output logic              wen,
    output logic [ADDR_W-1:0] w_addr,
    output logic [7:0]        w_data
);

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(COLS - 1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] idx, idx_next;
    logic              wen_next;
    logic [ADDR_W-1:0] addr_next;
    logic [7:0]        data_next;
    logic              cur_inc, cur_newline, cur_ret, cur_home, cur_back;
    logic              wrap;
    logic [ADDR_W-1:0] cur_addr, line_base;
    logic              accept, printable;

    assign in_ready  = (state == IDLE) && !clear;
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign printable = (in_data >= PRINT_LO) && (in_data <= PRINT_HI);

    vga_console_cursor #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_cursor (
        .clk       (clk),
        .rst       (rst),
        .inc       (cur_inc),
        .newline   (cur_newline),
        .ret       (cur_ret),
        .home      (cur_home),
        .back      (cur_back),
        .col       (cursor_x),
        .row       (cursor_y),
        .wrap      (wrap),
        .addr      (cur_addr),
        .line_base (line_base)
    );

    // Next-state, clear sweep and next write decode; a clear request aborts
    // whatever is in flight and suppresses this cycle's write.
    always_comb begin
        state_next  = state;
        idx_next    = idx;
        wen_next    = 1'b0;
        addr_next   = w_addr;
        data_next   = w_data;
        cur_inc     = 1'b0;
        cur_newline = 1'b0;
        cur_ret     = 1'b0;
        cur_home    = 1'b0;
        cur_back    = 1'b0;

        if (clear) begin
            state_next = CLEAR_ALL;
            idx_next   = '0;
            cur_home   = 1'b1;
        end else begin
            case (state)
                CLEAR_ALL: begin
                    wen_next  = 1'b1;
                    addr_next = idx;
                    data_next = BLANK;
                    if (idx == LAST_CELL) begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + ADDR_W'(1);
                    end
                end
                CLEAR_LINE: begin
                    wen_next  = 1'b1;
                    addr_next = line_base + idx;
                    data_next = BLANK;
                    if (idx == LAST_COL) begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + ADDR_W'(1);
                    end
                end
                default: begin
                    if (accept) begin
                        if (printable) begin
                            wen_next  = 1'b1;
                            addr_next = cur_addr;
                            data_next = in_data;
                            cur_inc   = 1'b1;
                            if (wrap) begin
                                state_next = CLEAR_LINE;
                                idx_next   = '0;
                            end
                        end else if (in_data == CH_LF) begin
                            cur_newline = 1'b1;
                            state_next  = CLEAR_LINE;
                            idx_next    = '0;
                        end else if (in_data == CH_CR) begin
                            cur_ret = 1'b1;
                        end else if (in_data == CH_BS) begin
                            if (cursor_x != 7'd0) begin
                                cur_back  = 1'b1;
                                wen_next  = 1'b1;
                                addr_next = cur_addr - ADDR_W'(1);
                                data_next = BLANK;
                            end
                        end else if (in_data == CH_FF) begin
                            state_next = CLEAR_ALL;
                            idx_next   = '0;
                            cur_home   = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // State, sweep index and registered write port; reset always re-blanks the screen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= CLEAR_ALL;
            idx    <= '0;
            wen    <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
        end else begin
            state  <= state_next;
            idx    <= idx_next;
            wen    <= wen_next;
            w_addr <= addr_next;
            w_data <= data_next;
        end
    end

endmodule
